cmd_stream_arbiter: RTL and testbench

// - Merges NUM_SRC AXI-Stream command sources (host DMA, display-list replay, ...) into the single command

---
 rtl/cmd_stream_arbiter_pkg.sv | 14 +
 rtl/cmd_stream_arbiter_axis_skid_buffer.sv | 58 +++++
 rtl/cmd_stream_arbiter.sv | 135 +++++++++++++
 tb/tb_cmd_stream_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_stream_arbiter_pkg.sv
// Shared definitions for the command stream arbiter: default data width,
// grant index width and the arbiter state encoding.
package cmd_stream_arbiter_pkg;

    localparam int unsigned DEFAULT_CMD_STREAM_WIDTH = 16;
    localparam int unsigned GRANT_W                  = 3;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ARB  = 2'd1,
        ARB_XFER = 2'd2
    } arb_state_t;

endpackage

// File: rtl/cmd_stream_arbiter_axis_skid_buffer.sv
// Two-entry AXI-Stream skid buffer. Upstream ready depends on occupancy
// only; the head entry is presented downstream and held until accepted.
module axis_skid_buffer #(
    parameter int unsigned WIDTH = 17
) (
    input  logic             aclk,
    input  logic             resetn,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             push;
    logic             pop;

    assign s_ready = (count != 2'd2);
    assign m_valid = (count != 2'd0);
    // Stale entries are masked so tlast reads 0 whenever the buffer is empty.
    assign m_data  = m_valid ? mem[rd_ptr] : '0;
    assign push    = s_valid & s_ready;
    assign pop     = m_valid & m_ready;

    // Storage write for accepted beats.
    always_ff @(posedge aclk) begin
        if (push) begin
            mem[wr_ptr] <= s_data;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge aclk) begin
        if (!resetn) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cmd_stream_arbiter.sv
// Packet-granular arbiter merging NUM_SRC command streams into one.
// High-class sources beat low-class ones; ties rotate round-robin.
module cmd_stream_arbiter
    import cmd_stream_arbiter_pkg::*;
#(
    parameter int unsigned CMD_STREAM_WIDTH = DEFAULT_CMD_STREAM_WIDTH,
    parameter int unsigned NUM_SRC          = 2
) (
    input  logic                                aclk,
    input  logic                                resetn,
    input  logic [NUM_SRC-1:0]                  s_cmd_axis_tvalid,
    output logic [NUM_SRC-1:0]                  s_cmd_axis_tready,
    input  logic [NUM_SRC-1:0]                  s_cmd_axis_tlast,
    input  logic [NUM_SRC*CMD_STREAM_WIDTH-1:0] s_cmd_axis_tdata,
    input  logic [NUM_SRC-1:0]                  src_high_prio,
    output logic                                m_cmd_axis_tvalid,
    input  logic                                m_cmd_axis_tready,
    output logic                                m_cmd_axis_tlast,
    output logic [CMD_STREAM_WIDTH-1:0]         m_cmd_axis_tdata,
    output logic [2:0]                          dbgGrant,
    output logic                                dbgGrantValid,
    output logic [15:0]                         dbgPacketCount
);

    localparam int unsigned SKID_W = CMD_STREAM_WIDTH + 1;

    arb_state_t                  state;
    logic [GRANT_W-1:0]          grant;
    logic [GRANT_W-1:0]          last_grant;
    logic [15:0]                 pkt_count;
    logic                        skid_ready;
    logic                        any_high;
    logic [NUM_SRC-1:0]          cand;
    logic [GRANT_W:0]            pick;
    logic                        beat;
    logic                        beat_last;
    logic [CMD_STREAM_WIDTH-1:0] beat_data;
    logic [SKID_W-1:0]           skid_out;

    // Returns {found, index}: first requester after 'last', wrapping around.
    function automatic logic [GRANT_W:0] rr_pick(input logic [NUM_SRC-1:0] req,
                                                 input logic [GRANT_W-1:0] last);
        logic [GRANT_W:0] res;
        int unsigned      idx;
        res = '0;
        for (int unsigned k = 1; k <= NUM_SRC; k++) begin
            idx = 32'(last) + k;
            if (idx >= NUM_SRC) begin
                idx = idx - NUM_SRC;
            end
            if (!res[GRANT_W] && (|(req & (NUM_SRC'(1) << idx)))) begin
                res = {1'b1, GRANT_W'(idx)};
            end
        end
        return res;
    endfunction

    // Class filter then round-robin pick among the surviving requesters.
    always_comb begin
        any_high = |(s_cmd_axis_tvalid & src_high_prio);
        cand     = any_high ? (s_cmd_axis_tvalid & src_high_prio) : s_cmd_axis_tvalid;
        pick     = rr_pick(cand, last_grant);
    end

    // Ready depends only on registered state, grant and skid occupancy.
    assign s_cmd_axis_tready = (state == ARB_XFER && skid_ready) ? (NUM_SRC'(1) << grant) : '0;

    // Select the beat of the granted source (at most one ready bit is set).
    always_comb begin
        beat      = 1'b0;
        beat_last = 1'b0;
        beat_data = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (s_cmd_axis_tready[i] && s_cmd_axis_tvalid[i]) begin
                beat      = 1'b1;
                beat_last = s_cmd_axis_tlast[i];
                beat_data = s_cmd_axis_tdata[i*CMD_STREAM_WIDTH +: CMD_STREAM_WIDTH];
            end
        end
    end

    // Arbitration FSM: grant is held from the first beat through tlast.
    always_ff @(posedge aclk) begin
        if (!resetn) begin
            state      <= ARB_IDLE;
            grant      <= '0;
            last_grant <= GRANT_W'(NUM_SRC - 1);
            pkt_count  <= '0;
        end else begin
            unique case (state)
                ARB_IDLE: begin
                    if (|s_cmd_axis_tvalid) begin
                        state <= ARB_ARB;
                    end
                end
                ARB_ARB: begin
                    if (pick[GRANT_W]) begin
                        grant <= pick[GRANT_W-1:0];
                        state <= ARB_XFER;
                    end else begin
                        state <= ARB_IDLE;
                    end
                end
                ARB_XFER: begin
                    if (beat && beat_last) begin
                        last_grant <= grant;
                        pkt_count  <= pkt_count + 16'd1;
                        state      <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    axis_skid_buffer #(
        .WIDTH(SKID_W)
    ) u_skid (
        .aclk    (aclk),
        .resetn  (resetn),
        .s_valid (beat),
        .s_ready (skid_ready),
        .s_data  ({beat_last, beat_data}),
        .m_valid (m_cmd_axis_tvalid),
        .m_ready (m_cmd_axis_tready),
        .m_data  (skid_out)
    );

    assign m_cmd_axis_tlast = skid_out[SKID_W-1];
    assign m_cmd_axis_tdata = skid_out[CMD_STREAM_WIDTH-1:0];
    assign dbgGrant         = grant;
    assign dbgGrantValid    = (state == ARB_XFER);
    assign dbgPacketCount   = pkt_count;

endmodule

// File: tb/tb_cmd_stream_arbiter.sv
// Self-checking bench for cmd_stream_arbiter: packet-level reference model
// (per-source packet queues, expected output sequence in grant order).
module tb_cmd_stream_arbiter;

    localparam int NSRC = 2;
    localparam int W    = 16;

    typedef struct {
        logic [W-1:0] data;
        logic         last;
    } beat_t;

    logic              aclk = 1'b0;
    logic              resetn = 1'b0;
    logic [NSRC-1:0]   s_tvalid = '0;
    logic [NSRC-1:0]   s_tready;
    logic [NSRC-1:0]   s_tlast = '0;
    logic [NSRC*W-1:0] s_tdata = '0;
    logic [NSRC-1:0]   prio = '0;
    logic              m_tvalid;
    logic              m_tready = 1'b1;
    logic              m_tlast;
    logic [W-1:0]      m_tdata;
    logic [2:0]        dbg_grant;
    logic              dbg_gv;
    logic [15:0]       dbg_cnt;

    cmd_stream_arbiter #(
        .CMD_STREAM_WIDTH(W),
        .NUM_SRC(NSRC)
    ) dut (
        .aclk              (aclk),
        .resetn            (resetn),
        .s_cmd_axis_tvalid (s_tvalid),
        .s_cmd_axis_tready (s_tready),
        .s_cmd_axis_tlast  (s_tlast),
        .s_cmd_axis_tdata  (s_tdata),
        .src_high_prio     (prio),
        .m_cmd_axis_tvalid (m_tvalid),
        .m_cmd_axis_tready (m_tready),
        .m_cmd_axis_tlast  (m_tlast),
        .m_cmd_axis_tdata  (m_tdata),
        .dbgGrant          (dbg_grant),
        .dbgGrantValid     (dbg_gv),
        .dbgPacketCount    (dbg_cnt)
    );

    always #5 aclk = ~aclk;

    // Reference model state
    beat_t srcq [NSRC][$];
    beat_t exp_out [$];
    int    grant_log [$];
    int    out_cyc [$];
    int    model_last = NSRC - 1;
    int    model_cnt  = 0;
    int    cur_grant  = 0;
    int    cyc        = 0;
    bit    src_en [NSRC];
    bit    rand_gaps  = 0;
    bit    rand_prio  = 0;
    int    mready_mode = 0;

    int    checks = 0;
    int    fails  = 0;

    // Values the upcoming clock edge sees
    logic [NSRC-1:0]   p_tv, p_tr, p_tl, p_pr;
    logic [NSRC*W-1:0] p_td;
    logic              p_mv, p_mr, p_ml, p_gv, p_rst;
    logic [W-1:0]      p_md;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Winner: among valid sources of the highest present class, the one
    // closest after the last completed grant in rotation order.
    function automatic int pick(input logic [NSRC-1:0] v, input logic [NSRC-1:0] p, input int last);
        int best = -1;
        int bestd = NSRC;
        bit hi = |(v & p);
        for (int i = 0; i < NSRC; i++) begin
            if (v[i] && (!hi || p[i])) begin
                int d = (i - last - 1 + 2 * NSRC) % NSRC;
                if (d < bestd) begin
                    bestd = d;
                    best = i;
                end
            end
        end
        return best;
    endfunction

    task automatic drive_src();
        for (int i = 0; i < NSRC; i++) begin
            if (src_en[i] && srcq[i].size() > 0 && (!rand_gaps || $urandom_range(0, 3) != 0)) begin
                s_tvalid[i] = 1'b1;
                s_tlast[i]  = srcq[i][0].last;
                s_tdata[i*W +: W] = srcq[i][0].data;
            end else begin
                s_tvalid[i] = 1'b0;
                s_tlast[i]  = 1'b0;
                s_tdata[i*W +: W] = '0;
            end
        end
        if (rand_prio) prio = NSRC'($urandom);
    endtask

    task automatic drive_ready();
        case (mready_mode)
            0:       m_tready = 1'b1;
            1:       m_tready = ~m_tready;
            default: m_tready = 1'($urandom);
        endcase
    endtask

    task automatic add_pkt(input int s, input int len, input logic [W-1:0] base, input bit rnd);
        for (int j = 0; j < len; j++) begin
            beat_t b;
            b.data = rnd ? W'($urandom) : base + W'(j);
            b.last = (j == len - 1);
            srcq[s].push_back(b);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NSRC; i++) srcq[i].delete();
        exp_out.delete();
        model_last = NSRC - 1;
        model_cnt  = 0;
        cur_grant  = 0;
    endtask

    // One clock: capture pre-edge values, wait for the edge, check, redrive.
    task automatic cycle();
        #4;
        p_tv = s_tvalid; p_tr = s_tready; p_tl = s_tlast; p_td = s_tdata; p_pr = prio;
        p_mv = m_tvalid; p_mr = m_tready; p_ml = m_tlast; p_md = m_tdata;
        p_gv = dbg_gv;   p_rst = resetn;
        @(negedge aclk);
        cyc++;
        if (!p_rst) begin
            check_eq("rst_m_tvalid", 32'(m_tvalid), 0);
            check_eq("rst_m_tlast", 32'(m_tlast), 0);
            check_eq("rst_s_tready", 32'(s_tready), 0);
            check_eq("rst_grant_valid", 32'(dbg_gv), 0);
            check_eq("rst_grant", 32'(dbg_grant), 0);
            check_eq("rst_pkt_count", 32'(dbg_cnt), 0);
            model_reset();
        end else begin
            if (p_mv && p_mr) begin
                out_cyc.push_back(cyc);
                if (exp_out.size() == 0) begin
                    check_eq("out_spurious", {16'd0, p_md}, 32'hFFFF_FFFF);
                end else begin
                    beat_t e = exp_out.pop_front();
                    check_eq("out_data", 32'(p_md), 32'(e.data));
                    check_eq("out_last", 32'(p_ml), 32'(e.last));
                end
            end
            if (p_mv && !p_mr) begin
                check_eq("stall_hold", {15'd0, m_tvalid, m_tlast, m_tdata}, {15'd0, 1'b1, p_ml, p_md});
            end
            for (int i = 0; i < NSRC; i++) begin
                if (p_tv[i] && p_tr[i]) begin
                    check_eq("hs_source", i, cur_grant);
                    if (!p_mv) begin
                        check_eq("latency", {15'd0, m_tvalid, m_tdata}, {15'd0, 1'b1, p_td[i*W +: W]});
                    end
                    if (srcq[i].size() > 0) void'(srcq[i].pop_front());
                    if (p_tl[i]) begin
                        model_cnt++;
                        model_last = cur_grant;
                    end
                end
            end
            if (dbg_gv && !p_gv) begin
                int e = pick(p_tv, p_pr, model_last);
                check_eq("grant", 32'(dbg_grant), e);
                cur_grant = e;
                grant_log.push_back(e);
                if (e >= 0) begin
                    foreach (srcq[e][k]) begin
                        exp_out.push_back(srcq[e][k]);
                        if (srcq[e][k].last) break;
                    end
                end
            end
            check_eq("tready_onehot", 32'(s_tready & ~(dbg_gv ? NSRC'(1) << cur_grant : NSRC'(0))), 0);
            check_eq("pkt_count", 32'(dbg_cnt), 32'(model_cnt & 16'hFFFF));
        end
        drive_src();
        drive_ready();
    endtask

    task automatic reset_dut();
        resetn = 1'b0;
        repeat (2) cycle();
        resetn = 1'b1;
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while (n < budget && !(srcq[0].size() == 0 && srcq[1].size() == 0 &&
               exp_out.size() == 0 && !dbg_gv && !m_tvalid)) begin
            cycle();
            n++;
        end
        check_eq(tag, 32'(n < budget), 1);
    endtask

    initial begin
        src_en[0] = 1'b1;
        src_en[1] = 1'b1;
        reset_dut();

        // Single 3-beat packet, back-to-back output
        add_pkt(0, 3, 16'h1001, 0);
        drive_src();
        out_cyc.delete();
        drain("t1_drain", 200);
        check_eq("t1_count", 32'(dbg_cnt), 1);
        check_eq("t1_nbeats", out_cyc.size(), 3);
        if (out_cyc.size() == 3) check_eq("t1_back_to_back", out_cyc[2] - out_cyc[0], 2);

        // Two low-class sources, round-robin
        reset_dut();
        grant_log.delete();
        add_pkt(0, 2, 16'h0a00, 0); add_pkt(0, 3, 16'h0a10, 0);
        add_pkt(1, 1, 16'h0b00, 0); add_pkt(1, 4, 16'h0b10, 0);
        drive_src();
        drain("t2_drain", 400);
        check_eq("t2_ngrants", grant_log.size(), 4);
        for (int k = 0; k < 4 && k < grant_log.size(); k++) check_eq("t2_order", grant_log[k], k % 2);

        // src1 high class monopolises until it runs dry
        grant_log.delete();
        prio = 2'b10;
        add_pkt(0, 2, 16'h0c00, 0); add_pkt(0, 2, 16'h0c10, 0);
        for (int k = 0; k < 3; k++) add_pkt(1, 2, 16'h0d00 + 16'(k * 16), 0);
        drive_src();
        drain("t3_drain", 400);
        check_eq("t3_ngrants", grant_log.size(), 5);
        for (int k = 0; k < 5 && k < grant_log.size(); k++) check_eq("t3_order", grant_log[k], k < 3 ? 1 : 0);
        prio = 2'b00;

        // Downstream ready toggling during a 10-beat packet
        out_cyc.delete();
        add_pkt(0, 10, 16'h2000, 0);
        drive_src();
        mready_mode = 1;
        drain("t4_drain", 400);
        check_eq("t4_nbeats", out_cyc.size(), 10);
        mready_mode = 0;

        // Granted source stalls mid-packet; other source must stay blocked
        reset_dut();
        grant_log.delete();
        add_pkt(0, 6, 16'h3000, 0);
        add_pkt(1, 3, 16'h4000, 0);
        drive_src();
        for (int k = 0; k < 200 && srcq[0].size() > 4; k++) cycle();
        check_eq("t5_reach_mid", 32'(srcq[0].size() <= 4), 1);
        src_en[0] = 1'b0;
        drive_src();
        for (int k = 0; k < 5; k++) begin
            cycle();
            check_eq("t5_src1_blocked", 32'(s_tready[1]), 0);
            check_eq("t5_grant_held", {31'd0, dbg_gv}, 1);
        end
        src_en[0] = 1'b1;
        drive_src();
        drain("t5_drain", 400);
        check_eq("t5_ngrants", grant_log.size(), 2);
        if (grant_log.size() == 2) check_eq("t5_order", {grant_log[0][15:0], grant_log[1][15:0]}, 32'h0000_0001);

        // One-cycle reset pulse mid-packet
        reset_dut();
        add_pkt(0, 8, 16'h5000, 0);
        add_pkt(1, 2, 16'h6000, 0);
        drive_src();
        for (int k = 0; k < 200 && srcq[0].size() > 5; k++) cycle();
        check_eq("t6_reach_mid", 32'(srcq[0].size() <= 5), 1);
        resetn = 1'b0;
        cycle();
        resetn = 1'b1;
        grant_log.delete();
        add_pkt(1, 2, 16'h6100, 0);
        add_pkt(0, 2, 16'h5100, 0);
        drive_src();
        drain("t6_drain", 400);
        check_eq("t6_first_grant", grant_log.size() > 0 ? grant_log[0] : -1, 0);
        check_eq("t6_count", 32'(dbg_cnt), 2);

        // Randomized traffic, gaps, priorities and backpressure
        reset_dut();
        rand_gaps = 1; rand_prio = 1; mready_mode = 2;
        for (int k = 0; k < 40; k++) add_pkt($urandom_range(0, NSRC - 1), $urandom_range(1, 6), '0, 1);
        drive_src();
        drain("t7_drain", 6000);
        check_eq("t7_count", 32'(dbg_cnt), 40);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
